soc_test_monitor: RTL and testbench
===================================

Name: soc_test_monitor

Overview:
- Parametrised, synthesizable end-of-test monitor for the riscv SoC harness.
- Snoops the core's instruction-fetch and data-memory buses. Replaces fixed-delay `$display`/`$finish` handling with registered completion detection, pass/fail decode, a cycle timeout and a stuck-PC hang detector.
- Sits beside riscv/inst_mem/data_mem at SoC top. The bench polls `done_o`.

Parameters:
- ADDR_W, 32, width of the instruction and data address buses.
- DATA_W, 32, data bus width.
- TOHOST_ADDR, 32'h0000_0100, data address whose store terminates the test.
- VERIFY_ADDR, 32'h0000_0104, data address whose store value is captured as the result; must differ from TOHOST_ADDR.
- CHECK_RESULT, 1, 1 = PASS also requires result == EXPECTED.
- EXPECTED, 32'd55, expected verify value.
- TIMEOUT_CYCLES, 1000, RUN cycles allowed before TIMEOUT; must be ≥ 2.
- STUCK_CYCLES, 16, consecutive identical fetch addresses that count as a hang; must be ≥ 2.
- CNT_W, 32, width of the cycle and store counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- inst_ce_i  in  1  instruction fetch enable.
- inst_addr_i  in  ADDR_W  fetch address.
- data_ce_i  in  1  data access enable.
- data_we_i  in  1  data write enable.
- data_addr_i  in  ADDR_W  data address.
- data_wdata_i  in  DATA_W  store data.
- done_o  out  1  test reached a terminal state.
- pass_o  out  1  terminal state is PASS.
- status_o  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HANG.
- fail_code_o  out  DATA_W  tohost value shifted right by 1; valid in FAIL.
- result_o  out  DATA_W  last value stored to VERIFY_ADDR.
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed.
- store_cnt_o  out  CNT_W  stores observed in RUN.

Behaviour:
- Reset (async assert, sync-deasserted use assumed by integration):
  - state IDLE.
  - All outputs 0; status_o = 0.
  - Internal last_pc and stuck counter are 0.
- All outputs are registered. A bus event sampled at edge N is visible on outputs after edge N.
- A store is any cycle with data_ce_i && data_we_i.

State machine:
- IDLE → RUN on the first edge with inst_ce_i = 1. Nothing is counted in IDLE.
- RUN, each edge:
  - cycle_cnt += 1, saturating at 2^CNT_W−1.
  - On a store, store_cnt += 1, saturating.
  - On a store to VERIFY_ADDR, result_o ← data_wdata_i. The last write wins.
- RUN exits are evaluated in this priority order:
  1. Store to TOHOST_ADDR:
     - Value 1, and either CHECK_RESULT = 0 or result_o == EXPECTED → PASS.
     - Otherwise → FAIL, with fail_code_o ← data_wdata_i >> 1.
     - result_o used in this check is the registered value, so a same-cycle verify store is impossible.
  2. cycle_cnt == TIMEOUT_CYCLES−1 on this edge → TIMEOUT.
  3. stuck_cnt reaches STUCK_CYCLES−1 → HANG.
- Stuck detection:
  - Active in RUN only, when inst_ce_i = 1.
  - If inst_addr_i == last_pc, stuck_cnt += 1; otherwise stuck_cnt ← 0.
  - last_pc ← inst_addr_i every cycle.
  - With inst_ce_i = 0, stuck_cnt holds.
- Terminal states (PASS/FAIL/TIMEOUT/HANG):
  - Sticky until rst.
  - Counters, result_o and fail_code_o freeze; later bus traffic is ignored.
  - done_o = 1; pass_o = 1 only in PASS.
- rst asserted mid-RUN or in a terminal state: immediate return to the reset values above.

Decomposition:
- Package soc_test_pkg:
  - State/status encodings (IDLE..HANG, 3-bit).
  - Default TOHOST/VERIFY addresses.
  - PASS_TOKEN = 1.
- Sub-module pc_stuck_detector:
  - Parameters ADDR_W, STUCK_CYCLES.
  - Inputs clk, rst, en, ce, addr.
  - Output stuck pulse.
- The top holds the FSM, counters and captures.

Test Plan:
- Pass path: rst 300 ps, then fetch PC 0,4,8…; store 55 to 0x104, then 1 to 0x100 → next cycle done_o = 1, pass_o = 1, status_o = 2, result_o = 55, store_cnt_o = 2.
- Fail code: store 7 to 0x100 → status_o = 3, pass_o = 0, fail_code_o = 3. A subsequent store of 1 to 0x100 leaves the state unchanged.
- Result mismatch: CHECK_RESULT = 1; store 54 to 0x104, then 1 to 0x100 → FAIL, fail_code_o = 0.
- Timeout and priority:
  - TIMEOUT_CYCLES = 20 with an incrementing PC and no tohost store → status_o = 4 with cycle_cnt_o = 20, frozen.
  - Repeat with a tohost = 1 store exactly on the 20th RUN cycle → PASS wins.
- Hang: PC held at 0x40 with inst_ce_i = 1, STUCK_CYCLES = 16 → HANG after 16 identical fetches.
  - Dropping inst_ce_i for 5 cycles mid-sequence does not reset the count.
  - A single PC change does reset it.
- Reset mid-run: assert rst asynchronously between edges while in RUN with cycle_cnt_o = 10 → all outputs 0 immediately, status_o = 0. After rst falls, no counting until the first inst_ce_i.

Source files
------------

// File: rtl/soc_test_pkg.sv
// Shared definitions for the SoC end-of-test monitor.
//   state_e           : monitor state, also driven out directly as status_o
//   DEF_TOHOST_ADDR   : default address whose store ends the test
//   DEF_VERIFY_ADDR   : default address whose store value is the test result
//   PASS_TOKEN        : tohost value that means "test passed"
package soc_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } state_e;

  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_0100;
  localparam logic [31:0] DEF_VERIFY_ADDR = 32'h0000_0104;
  localparam int unsigned PASS_TOKEN      = 1;

  function automatic logic is_terminal(input state_e st);
    return (st == ST_PASS) || (st == ST_FAIL) ||
           (st == ST_TIMEOUT) || (st == ST_HANG);
  endfunction

endpackage

// File: rtl/soc_test_monitor_pc_stuck.sv
// Stuck-PC detector: counts consecutive fetches of the same address.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : detector active (monitor in RUN); when low everything holds
//   ce       : fetch enable; cycles without a fetch neither count nor clear
//   addr     : fetch address
//   stuck    : combinational pulse on the fetch whose count reaches
//              STUCK_CYCLES-1, so the caller registers HANG on that edge
module pc_stuck_detector #(
  parameter int ADDR_W       = 32,
  parameter int STUCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  output logic              stuck
);

  localparam int CW = $clog2(STUCK_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STUCK_CYCLES - 1);

  logic [ADDR_W-1:0] last_pc_q, last_pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    last_pc_d = last_pc_q;
    cnt_d     = cnt_q;
    stuck     = 1'b0;
    if (en && ce) begin
      last_pc_d = addr;
      if (addr == last_pc_q) begin
        // Saturate so a held PC never wraps back to zero.
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
      stuck = (cnt_d == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/soc_test_monitor.sv
// End-of-test monitor for the riscv SoC harness. Snoops the fetch and data
// buses, detects the tohost store, decodes pass/fail, and flags timeout and
// stuck-PC hangs. All outputs come straight from registers.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   inst_ce_i/addr_i    : instruction fetch enable / address
//   data_ce_i/we_i      : data access enable / write enable (store = both)
//   data_addr_i/wdata_i : data address / store data
//   done_o, pass_o      : terminal state reached / terminal state is PASS
//   status_o            : state encoding (see soc_test_pkg::state_e)
//   fail_code_o         : tohost value >> 1, meaningful in FAIL
//   result_o            : last value stored to VERIFY_ADDR
//   cycle_cnt_o         : RUN cycles elapsed (saturating)
//   store_cnt_o         : stores seen in RUN (saturating)
//
// state   | meaning
// IDLE    | waiting for the first fetch
// RUN     | program executing; counters and captures live
// PASS    | tohost == PASS_TOKEN and result check satisfied
// FAIL    | any other tohost value, or result mismatch
// TIMEOUT | RUN lasted TIMEOUT_CYCLES cycles
// HANG    | fetch PC held for STUCK_CYCLES consecutive fetches
module soc_test_monitor
  import soc_test_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEF_TOHOST_ADDR),
  parameter logic [ADDR_W-1:0] VERIFY_ADDR    = ADDR_W'(DEF_VERIFY_ADDR),
  parameter bit                CHECK_RESULT   = 1'b1,
  parameter logic [DATA_W-1:0] EXPECTED       = DATA_W'(55),
  parameter int                TIMEOUT_CYCLES = 1000,
  parameter int                STUCK_CYCLES   = 16,
  parameter int                CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              done_o,
  output logic              pass_o,
  output logic [2:0]        status_o,
  output logic [DATA_W-1:0] fail_code_o,
  output logic [DATA_W-1:0] result_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  store_cnt_o
);

  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_CMP = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] PASS_VAL    = DATA_W'(PASS_TOKEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  store_cnt_q, store_cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] fail_code_q, fail_code_d;

  logic in_run;
  logic is_store;
  logic tohost_store;
  logic result_ok;
  logic stuck;

  assign in_run       = (state_q == ST_RUN);
  assign is_store     = data_ce_i && data_we_i;
  assign tohost_store = is_store && (data_addr_i == TOHOST_ADDR);
  // Uses the registered result: a verify store on this same edge cannot
  // also be the tohost store, so there is no bypass to worry about.
  assign result_ok    = !CHECK_RESULT || (result_q == EXPECTED);

  pc_stuck_detector #(
    .ADDR_W       (ADDR_W),
    .STUCK_CYCLES (STUCK_CYCLES)
  ) u_stuck (
    .clk   (clk),
    .rst   (rst),
    .en    (in_run),
    .ce    (inst_ce_i),
    .addr  (inst_addr_i),
    .stuck (stuck)
  );

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    store_cnt_d = store_cnt_q;
    result_d    = result_q;
    fail_code_d = fail_code_q;

    case (state_q)
      ST_IDLE: begin
        if (inst_ce_i) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (cycle_cnt_q != CNT_MAX) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (is_store) begin
          if (store_cnt_q != CNT_MAX) begin
            store_cnt_d = store_cnt_q + CNT_W'(1);
          end
          if (data_addr_i == VERIFY_ADDR) begin
            result_d = data_wdata_i;
          end
        end

        // Exit priority: tohost store, then timeout, then hang.
        if (tohost_store) begin
          if ((data_wdata_i == PASS_VAL) && result_ok) begin
            state_d = ST_PASS;
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = data_wdata_i >> 1;
          end
        end else if (cycle_cnt_q == TIMEOUT_CMP) begin
          state_d = ST_TIMEOUT;
        end else if (stuck) begin
          state_d = ST_HANG;
        end
      end

      default: begin
        // Terminal states hold everything until reset.
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= '0;
      store_cnt_q <= '0;
      result_q    <= '0;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      store_cnt_q <= store_cnt_d;
      result_q    <= result_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign done_o      = is_terminal(state_q);
  assign pass_o      = (state_q == ST_PASS);
  assign status_o    = state_q;
  assign fail_code_o = fail_code_q;
  assign result_o    = result_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign store_cnt_o = store_cnt_q;

endmodule

// File: tb/tb_soc_test_monitor.sv
`timescale 1ns/1ps
module tb_soc_test_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic        data_ce;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;

  // a: default timeout 1000; t: timeout 20
  logic        done_a, pass_a, done_t, pass_t;
  logic [2:0]  status_a, status_t;
  logic [31:0] fail_a, result_a, cyc_a, st_a;
  logic [31:0] fail_t, result_t, cyc_t, st_t;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  soc_test_monitor #(.TIMEOUT_CYCLES(1000)) dut_a (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce), .inst_addr_i(inst_addr),
    .data_ce_i(data_ce), .data_we_i(data_we),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .done_o(done_a), .pass_o(pass_a), .status_o(status_a),
    .fail_code_o(fail_a), .result_o(result_a),
    .cycle_cnt_o(cyc_a), .store_cnt_o(st_a)
  );

  soc_test_monitor #(.TIMEOUT_CYCLES(20)) dut_t (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce), .inst_addr_i(inst_addr),
    .data_ce_i(data_ce), .data_we_i(data_we),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .done_o(done_t), .pass_o(pass_t), .status_o(status_t),
    .fail_code_o(fail_t), .result_o(result_t),
    .cycle_cnt_o(cyc_t), .store_cnt_o(st_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later.
  task automatic step(input logic ce, input logic [31:0] pc,
                      input logic st, input logic [31:0] da, input logic [31:0] dw);
    inst_ce    = ce;
    inst_addr  = pc;
    data_ce    = st;
    data_we    = st;
    data_addr  = da;
    data_wdata = dw;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    inst_ce = 0; inst_addr = 0; data_ce = 0; data_we = 0; data_addr = 0; data_wdata = 0;
    #0.3 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    // Reset values
    do_reset();
    chk("rst_status", 32'(status_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_cycle", cyc_a, 32'd0);
    chk("rst_store", st_a, 32'd0);
    chk("rst_result", result_a, 32'd0);
    chk("rst_fail", fail_a, 32'd0);

    // Pass path
    fetch(32'h0);
    chk("pass_run", 32'(status_a), 32'd1);
    chk("pass_cyc0", cyc_a, 32'd0);
    fetch(32'h4);
    chk("pass_cyc1", cyc_a, 32'd1);
    step(1'b1, 32'h8, 1'b1, 32'h104, 32'd55);
    chk("pass_res_cap", result_a, 32'd55);
    chk("pass_st1", st_a, 32'd1);
    step(1'b1, 32'hC, 1'b1, 32'h100, 32'd1);
    chk("pass_done", 32'(done_a), 32'd1);
    chk("pass_pass", 32'(pass_a), 32'd1);
    chk("pass_status", 32'(status_a), 32'd2);
    chk("pass_result", result_a, 32'd55);
    chk("pass_store", st_a, 32'd2);
    chk("pass_cyc", cyc_a, 32'd3);
    step(1'b1, 32'h10, 1'b1, 32'h104, 32'd9);
    chk("pass_frz_res", result_a, 32'd55);
    chk("pass_frz_st", st_a, 32'd2);
    chk("pass_frz_cyc", cyc_a, 32'd3);
    chk("pass_frz_status", 32'(status_a), 32'd2);

    // Fail code
    do_reset();
    fetch(32'h0);
    step(1'b1, 32'h4, 1'b1, 32'h100, 32'd7);
    chk("fail_status", 32'(status_a), 32'd3);
    chk("fail_pass", 32'(pass_a), 32'd0);
    chk("fail_done", 32'(done_a), 32'd1);
    chk("fail_code", fail_a, 32'd3);
    step(1'b1, 32'h8, 1'b1, 32'h100, 32'd1);
    chk("fail_sticky", 32'(status_a), 32'd3);
    chk("fail_code_frz", fail_a, 32'd3);

    // Result mismatch
    do_reset();
    fetch(32'h0);
    step(1'b1, 32'h4, 1'b1, 32'h104, 32'd54);
    step(1'b1, 32'h8, 1'b1, 32'h100, 32'd1);
    chk("mis_status", 32'(status_a), 32'd3);
    chk("mis_code", fail_a, 32'd0);
    chk("mis_result", result_a, 32'd54);

    // Timeout (dut_t, 20 cycles)
    do_reset();
    fetch(32'h0);
    for (int i = 1; i <= 19; i++) fetch(32'(4 * i));
    chk("to_pre_status", 32'(status_t), 32'd1);
    chk("to_pre_cyc", cyc_t, 32'd19);
    fetch(32'd80);
    chk("to_status", 32'(status_t), 32'd4);
    chk("to_cyc", cyc_t, 32'd20);
    chk("to_done", 32'(done_t), 32'd1);
    chk("to_pass", 32'(pass_t), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'(84 + 4 * i), 1'b1, 32'h100, 32'd1);
    chk("to_frz_status", 32'(status_t), 32'd4);
    chk("to_frz_cyc", cyc_t, 32'd20);
    chk("to_frz_st", st_t, 32'd0);

    // Tohost on the 20th RUN cycle beats timeout
    do_reset();
    fetch(32'h0);
    for (int i = 1; i <= 19; i++) begin
      if (i == 5) step(1'b1, 32'(4 * i), 1'b1, 32'h104, 32'd55);
      else        fetch(32'(4 * i));
    end
    chk("prio_pre_cyc", cyc_t, 32'd19);
    step(1'b1, 32'd80, 1'b1, 32'h100, 32'd1);
    chk("prio_status", 32'(status_t), 32'd2);
    chk("prio_pass", 32'(pass_t), 32'd1);
    chk("prio_cyc", cyc_t, 32'd20);

    // Hang with a 5-cycle fetch gap
    do_reset();
    fetch(32'h40);
    for (int i = 0; i < 8; i++) fetch(32'h40);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h40, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) fetch(32'h40);
    chk("hang_gap_pre", 32'(status_a), 32'd1);
    fetch(32'h40);
    chk("hang_gap_status", 32'(status_a), 32'd5);
    chk("hang_gap_done", 32'(done_a), 32'd1);
    chk("hang_gap_cyc", cyc_a, 32'd21);

    // Hang count cleared by a single PC change
    do_reset();
    fetch(32'h40);
    for (int i = 0; i < 10; i++) fetch(32'h40);
    fetch(32'h44);
    for (int i = 0; i < 15; i++) fetch(32'h40);
    chk("hang_clr_pre", 32'(status_a), 32'd1);
    fetch(32'h40);
    chk("hang_clr_status", 32'(status_a), 32'd5);

    // Asynchronous reset mid-run
    do_reset();
    fetch(32'h0);
    for (int i = 1; i <= 10; i++) step(1'b1, 32'(4 * i), 1'b1, 32'h200, 32'd3);
    chk("mr_cyc", cyc_a, 32'd10);
    chk("mr_st", st_a, 32'd10);
    #2 rst = 1'b1;
    #1;
    chk("mr_status", 32'(status_a), 32'd0);
    chk("mr_cyc0", cyc_a, 32'd0);
    chk("mr_st0", st_a, 32'd0);
    chk("mr_done", 32'(done_a), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 32'h200, 32'd3);
    chk("mr_idle_status", 32'(status_a), 32'd0);
    chk("mr_idle_cyc", cyc_a, 32'd0);
    chk("mr_idle_st", st_a, 32'd0);
    fetch(32'h0);
    chk("mr_rerun", 32'(status_a), 32'd1);
    chk("mr_rerun_cyc", cyc_a, 32'd0);
    fetch(32'h4);
    chk("mr_rerun_cyc1", cyc_a, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
